// File: rtl/a5_regs_pkg.sv
// Register map, ID constant, STATUS bit positions and FSM encoding shared by the
// A5/1 keystream fetcher and its Wishbone transfer engine.
package a5_regs_pkg;

    localparam logic [7:0] REG_ID      = 8'h00;
    localparam logic [7:0] REG_STATUS  = 8'h04;
    localparam logic [7:0] REG_CONTROL = 8'h08;
    localparam logic [7:0] REG_DATA    = 8'h0C;
    localparam logic [7:0] REG_KEY_LO  = 8'h10;
    localparam logic [7:0] REG_KEY_HI  = 8'h14;
    localparam logic [7:0] REG_FRAME   = 8'h18;

    localparam logic [31:0] A5_ID_VALUE = 32'h4135_4135;

    localparam int STATUS_NOT_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT      = 1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHK_ID    = 4'd1,
        S_WR_KEY_LO = 4'd2,
        S_WR_KEY_HI = 4'd3,
        S_WR_FRAME  = 4'd4,
        S_WR_CTRL   = 4'd5,
        S_POLL      = 4'd6,
        S_RD_DATA   = 4'd7,
        S_OUT       = 4'd8
    } fetch_state_e;

    // One bus request as launched towards the transfer engine.
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [7:0]  off;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic bus_req_t wr_req(input logic [7:0] off, input logic [31:0] wdata);
        bus_req_t r;
        r.valid = 1'b1;
        r.we    = 1'b1;
        r.off   = off;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic bus_req_t rd_req(input logic [7:0] off);
        bus_req_t r;
        r.valid = 1'b1;
        r.we    = 1'b0;
        r.off   = off;
        r.wdata = 32'h0;
        return r;
    endfunction

endpackage

// File: rtl/a5_wb_xfer.sv
// Single-transfer Wishbone classic engine: registered bus outputs, an idle cycle
// after every acknowledged or timed-out transfer, and a per-transfer ack timeout.
module a5_wb_xfer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack_done,
    output logic        timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ack_done_q, ack_done_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdata_d    = rdata_q;
        ack_done_d = 1'b0;
        timeout_d  = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;

        if (cyc_q) begin
            if (wbm_ack_i) begin
                ack_done_d = 1'b1;
                rdata_d    = wbm_dat_i;
            end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
            if (wbm_ack_i || timeout_d) begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
                sel_d = 4'h0;
                adr_d = 32'h0;
                dat_d = 32'h0;
            end
        end else if (req) begin
            // Requests only arrive once ack_done/timeout is seen, i.e. in the cycle the
            // bus is already low, which gives the mandatory idle gap for free.
            cyc_d     = 1'b1;
            we_d      = we;
            sel_d     = 4'hF;
            adr_d     = addr;
            dat_d     = wdata;
            tmo_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values; the async
    // reset drops the bus immediately without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            rdata_q    <= 32'h0;
            ack_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdata_q    <= rdata_d;
            ack_done_q <= ack_done_d;
            timeout_q  <= timeout_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rdata     = rdata_q;
    assign ack_done  = ack_done_q;
    assign timeout   = timeout_q;

endmodule

// File: rtl/a5_keystream_fetcher.sv
// Wishbone initiator that programs the A5/1 target, triggers a load and streams DATA
// words out on valid/ready. Define A5_ID_CHECK_EN to read and verify the ID register first.
module a5_keystream_fetcher
    import a5_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned POLL_MAX  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    input  logic [7:0]  num_words,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] ks_data,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned PCW = $clog2(POLL_MAX + 1);

    fetch_state_e   state_q, state_d;
    logic [63:0]    key_q, key_d;
    logic [21:0]    frame_q, frame_d;
    logic [7:0]     num_words_q, num_words_d;
    logic [7:0]     word_cnt_q, word_cnt_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic [31:0]    ks_data_q, ks_data_d;
    logic           ks_valid_q, ks_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;

    bus_req_t       breq;
    logic [31:0]    breq_addr;
    logic [31:0]    xfer_rdata;
    logic           xfer_ack_done;
    logic           xfer_timeout;

    assign breq_addr = BASE_ADDR + {24'h0, breq.off};

    a5_wb_xfer #(
        .TIMEOUT(TIMEOUT)
    ) u_xfer (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (breq.valid),
        .addr      (breq_addr),
        .we        (breq.we),
        .wdata     (breq.wdata),
        .rdata     (xfer_rdata),
        .ack_done  (xfer_ack_done),
        .timeout   (xfer_timeout),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        frame_d     = frame_q;
        num_words_d = num_words_q;
        word_cnt_d  = word_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        ks_data_d   = ks_data_q;
        ks_valid_d  = ks_valid_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        breq        = '0;

        // Each transition into a bus state launches that state's transfer in the same
        // cycle, so the first stb lands at T+1 and transfers run back to back.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d       = key;
                    frame_d     = frame;
                    num_words_d = num_words;
                    word_cnt_d  = 8'd0;
                    poll_cnt_d  = '0;
`ifdef A5_ID_CHECK_EN
                    state_d = S_CHK_ID;
                    breq    = rd_req(REG_ID);
`else
                    state_d = S_WR_KEY_LO;
                    breq    = wr_req(REG_KEY_LO, key[31:0]);
`endif
                end
            end
`ifdef A5_ID_CHECK_EN
            S_CHK_ID: begin
                if (xfer_ack_done) begin
                    if (xfer_rdata != A5_ID_VALUE) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WR_KEY_LO;
                        breq    = wr_req(REG_KEY_LO, key_q[31:0]);
                    end
                end
            end
`endif
            S_WR_KEY_LO: begin
                if (xfer_ack_done) begin
                    state_d = S_WR_KEY_HI;
                    breq    = wr_req(REG_KEY_HI, key_q[63:32]);
                end
            end
            S_WR_KEY_HI: begin
                if (xfer_ack_done) begin
                    state_d = S_WR_FRAME;
                    breq    = wr_req(REG_FRAME, {10'b0, frame_q});
                end
            end
            S_WR_FRAME: begin
                if (xfer_ack_done) begin
                    state_d = S_WR_CTRL;
                    breq    = wr_req(REG_CONTROL, 32'h1);
                end
            end
            S_WR_CTRL: begin
                if (xfer_ack_done) begin
                    if (num_words_q == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_POLL;
                        breq    = rd_req(REG_STATUS);
                    end
                end
            end
            S_POLL: begin
                if (xfer_ack_done) begin
                    if (xfer_rdata[STATUS_NOT_EMPTY_BIT]) begin
                        state_d = S_RD_DATA;
                        breq    = rd_req(REG_DATA);
                    end else if (poll_cnt_q == PCW'(POLL_MAX - 1)) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PCW'(1);
                        breq       = rd_req(REG_STATUS);
                    end
                end
            end
            S_RD_DATA: begin
                if (xfer_ack_done) begin
                    ks_data_d  = xfer_rdata;
                    ks_valid_d = 1'b1;
                    poll_cnt_d = '0;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (ks_ready) begin
                    ks_valid_d = 1'b0;
                    word_cnt_d = word_cnt_q + 8'd1;
                    if (word_cnt_q + 8'd1 == num_words_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_POLL;
                        breq    = rd_req(REG_STATUS);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The engine has already dropped the bus on a timeout; abandon the run.
        if (xfer_timeout) begin
            error_d    = 1'b1;
            done_d     = 1'b0;
            ks_valid_d = 1'b0;
            state_d    = S_IDLE;
            breq       = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            key_q       <= 64'h0;
            frame_q     <= 22'h0;
            num_words_q <= 8'd0;
            word_cnt_q  <= 8'd0;
            poll_cnt_q  <= '0;
            ks_data_q   <= 32'h0;
            ks_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            frame_q     <= frame_d;
            num_words_q <= num_words_d;
            word_cnt_q  <= word_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            ks_data_q   <= ks_data_d;
            ks_valid_q  <= ks_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign ks_data  = ks_data_q;
    assign ks_valid = ks_valid_q;

endmodule
